// File: rtl/mx_norm_pkg.sv
// Shared types, constants and helpers for the MX product normaliser.
// Default lane widths, saturation patterns and a leading-zero counter.
package mx_norm_pkg;

    localparam int DEF_IN_E_W  = 3;
    localparam int DEF_IN_M_W  = 8;
    localparam int DEF_OUT_E_W = 2;
    localparam int DEF_OUT_M_W = 3;
    localparam int DEF_LANES   = 4;
    localparam int DEF_CNT_W   = 16;

    typedef logic [DEF_IN_E_W-1:0]  lane_in_e_t;
    typedef logic [DEF_IN_M_W-1:0]  lane_in_m_t;
    typedef logic [DEF_OUT_E_W-1:0] lane_out_e_t;
    typedef logic [DEF_OUT_M_W-1:0] lane_out_m_t;

    localparam lane_out_e_t SAT_E = '1;
    localparam lane_out_m_t SAT_M = '1;

    // Zeros counted from bit msb downward; msb+1 if no one is found.
    function automatic int lzc(input logic [63:0] v, input int msb);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i <= msb && !hit) begin
                if (v[i]) hit = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mult_norm_lane.sv
// Stage-2 lane datapath: shift, optional RNE (MULT_NORM_RNE_EN), saturate.
// In: e/m/lz/sh/ovf/zero from stage 1. Out: res_e, res_m, sat.
module mult_norm_lane
    import mx_norm_pkg::*;
#(
    parameter int IN_E_W  = DEF_IN_E_W,
    parameter int IN_M_W  = DEF_IN_M_W,
    parameter int OUT_E_W = DEF_OUT_E_W,
    parameter int OUT_M_W = DEF_OUT_M_W,
    parameter int LZ_W    = $clog2(DEF_IN_M_W) + 1
) (
    input  logic [IN_E_W-1:0]  e,
    input  logic [IN_M_W-1:0]  m,
    input  logic [LZ_W-1:0]    lz,
    input  logic [LZ_W-1:0]    sh,
    input  logic               ovf,
    input  logic               zero,
    output logic [OUT_E_W-1:0] res_e,
    output logic [OUT_M_W-1:0] res_m,
    output logic               sat
);

    localparam int XE_W = IN_E_W + 1;
    localparam int G    = IN_M_W - 3 - OUT_M_W;
    localparam logic [XE_W-1:0] E_MAX = XE_W'((1 << OUT_E_W) - 1);

    logic [IN_M_W-1:0]  nm;
    logic [XE_W-1:0]    ne;
    logic               lost;
    logic [OUT_M_W-1:0] mant;
    logic [XE_W-1:0]    fe;
    logic [OUT_M_W-1:0] fm;

    always_comb begin
        nm   = m;
        ne   = {1'b0, e};
        lost = 1'b0;
        if (m[IN_M_W-1]) begin
            nm   = m >> 1;
            ne   = {1'b0, e} + XE_W'(1);
            lost = m[0];
        end else begin
            nm = m << sh;
            // leading one never reached: subnormal, exponent pinned at 0
            ne = (lz > sh) ? {XE_W{1'b0}}
                           : {1'b0, e} - XE_W'(sh);
        end
    end

    assign mant = nm[IN_M_W-3 -: OUT_M_W];

`ifdef MULT_NORM_RNE_EN
    logic               guard;
    logic               sticky;
    logic               inc;
    logic [OUT_M_W:0]   sum;
    logic               unused;

    assign guard  = nm[G];
    assign sticky = (|nm[G-1:0]) | lost;
    assign inc    = guard & (sticky | mant[0]);
    assign sum    = {1'b0, mant} + (OUT_M_W+1)'(inc);
    assign fm     = sum[OUT_M_W] ? '0 : sum[OUT_M_W-1:0];
    assign fe     = ne + XE_W'(sum[OUT_M_W]);
    assign unused = ^nm[IN_M_W-1:IN_M_W-2];
`else
    logic unused;

    assign fm     = mant;
    assign fe     = ne;
    assign unused = ^{nm[IN_M_W-1:IN_M_W-2], nm[G:0], lost};
`endif

    always_comb begin
        res_e = fe[OUT_E_W-1:0];
        res_m = fm;
        sat   = 1'b0;
        if (ovf) begin
            res_e = '1;
            res_m = '1;
            sat   = 1'b1;
        end else if (zero) begin
            res_e = '0;
            res_m = '0;
        end else if (fe > E_MAX) begin
            res_e = '1;
            res_m = '1;
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/mult_normalizer_pipe.sv
// 2-stage, LANES-wide valid/ready normaliser with saturation counter.
// Ports: in_valid/in_ready/in_e/in_m, out_valid/out_ready/out_e/out_m/out_sat,
// sat_cnt/sat_cnt_clr. Option: MULT_NORM_RNE_EN enables round-to-nearest-even.
module mult_normalizer_pipe
    import mx_norm_pkg::*;
#(
    parameter int IN_E_W    = DEF_IN_E_W,
    parameter int IN_M_W    = DEF_IN_M_W,
    parameter int OUT_E_W   = DEF_OUT_E_W,
    parameter int OUT_M_W   = DEF_OUT_M_W,
    parameter int LANES     = DEF_LANES,
    parameter int SAT_CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*IN_E_W-1:0]    in_e,
    input  logic [LANES*IN_M_W-1:0]    in_m,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_E_W-1:0]   out_e,
    output logic [LANES*OUT_M_W-1:0]   out_m,
    output logic [LANES-1:0]           out_sat,
    output logic [SAT_CNT_W-1:0]       sat_cnt,
    input  logic                       sat_cnt_clr
);

    localparam int LZ_W = $clog2(IN_M_W) + 1;

    logic                          s1_valid;
    logic [LANES-1:0][IN_E_W-1:0]  s1_e;
    logic [LANES-1:0][IN_M_W-1:0]  s1_m;
    logic [LANES-1:0][LZ_W-1:0]    s1_lz;
    logic [LANES-1:0][LZ_W-1:0]    s1_sh;
    logic [LANES-1:0]              s1_ovf;
    logic [LANES-1:0]              s1_zero;

    logic [LANES-1:0][LZ_W-1:0]    lz_c;
    logic [LANES-1:0][LZ_W-1:0]    sh_c;
    logic [LANES-1:0]              ovf_c;
    logic [LANES-1:0]              zero_c;

    logic [LANES-1:0][OUT_E_W-1:0] le;
    logic [LANES-1:0][OUT_M_W-1:0] lm;
    logic [LANES-1:0]              ls;
    logic [LANES-1:0][OUT_E_W-1:0] e_q;
    logic [LANES-1:0][OUT_M_W-1:0] m_q;

    logic                          s2_free;
    logic [SAT_CNT_W:0]            pc;
    logic [SAT_CNT_W:0]            sum;

    assign s2_free  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_free;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IN_E_W-2:0] e_lo;
        logic [LZ_W-1:0]   e_x;

        assign e_lo      = in_e[i*IN_E_W +: IN_E_W-1];
        assign e_x       = LZ_W'(e_lo);
        assign lz_c[i]   = LZ_W'(lzc(64'(in_m[i*IN_M_W +: IN_M_W]),
                                     IN_M_W - 2));
        assign sh_c[i]   = (lz_c[i] < e_x) ? lz_c[i] : e_x;
        assign ovf_c[i]  = in_e[i*IN_E_W + IN_E_W - 1];
        assign zero_c[i] = (in_m[i*IN_M_W +: IN_M_W] == '0);

        mult_norm_lane #(
            .IN_E_W  (IN_E_W),
            .IN_M_W  (IN_M_W),
            .OUT_E_W (OUT_E_W),
            .OUT_M_W (OUT_M_W),
            .LZ_W    (LZ_W)
        ) u_lane (
            .e     (s1_e[i]),
            .m     (s1_m[i]),
            .lz    (s1_lz[i]),
            .sh    (s1_sh[i]),
            .ovf   (s1_ovf[i]),
            .zero  (s1_zero[i]),
            .res_e (le[i]),
            .res_m (lm[i]),
            .sat   (ls[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_e     <= '0;
            s1_m     <= '0;
            s1_lz    <= '0;
            s1_sh    <= '0;
            s1_ovf   <= '0;
            s1_zero  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_e    <= in_e;
                s1_m    <= in_m;
                s1_lz   <= lz_c;
                s1_sh   <= sh_c;
                s1_ovf  <= ovf_c;
                s1_zero <= zero_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            e_q       <= '0;
            m_q       <= '0;
            out_sat   <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                e_q     <= le;
                m_q     <= lm;
                out_sat <= ls;
            end
        end
    end

    assign out_e = e_q;
    assign out_m = m_q;

    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) begin
            pc = pc + (SAT_CNT_W+1)'(out_sat[i]);
        end
        sum = {1'b0, sat_cnt} + pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            sat_cnt <= sum[SAT_CNT_W] ? '1 : sum[SAT_CNT_W-1:0];
        end
    end

endmodule
